matriz_scan: RTL

MATRIZ_SCAN -- requirements
Module: matriz_scan

---
 rtl/matriz_scan_if.sv | 27 ++
 rtl/matriz_scan.sv | 109 ++++++++++
 2 files changed

// File: rtl/matriz_scan_if.sv
// Bundles the scan controller's control, write-port and display signals.
// The master drives control and writes; the slave (matriz_scan) drives the display side.
interface matriz_scan_if #(
  parameter int COLS = 5
) ();
  logic            enable;
  logic [7:0]      dwell;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [COLS-1:0] wr_data;
  logic            swap;
  logic [2:0]      func;
  logic [COLS-1:0] col_n;
  logic            frame_done;
  logic            swap_pending;
  logic            busy;

  modport master (
    output enable, dwell, wr_en, wr_addr, wr_data, swap,
    input  func, col_n, frame_done, swap_pending, busy
  );

  modport slave (
    input  enable, dwell, wr_en, wr_addr, wr_data, swap,
    output func, col_n, frame_done, swap_pending, busy
  );
endinterface

// File: rtl/matriz_scan.sv
// Double-buffered 7-row LED matrix scanner: blanks one cycle between rows, shows
// each row for dwell+1 cycles, and exchanges front/back buffers only at frame end.
module matriz_scan #(
  parameter int COLS = 5
) (
  input  logic          clk,
  input  logic          rst,
  matriz_scan_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_row, w_row_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [2:0]      r_func, w_func_nxt;
  logic [COLS-1:0] r_col_n, w_col_n_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic            r_swap_pending, w_swap_pending_nxt;
  logic            r_busy;
  logic            r_sel;                 // bank currently acting as front
  logic [COLS-1:0] r_bank [2][7];

  logic [2:0]      w_row_idx;
  logic [2:0]      w_wr_idx;
  logic [COLS-1:0] w_front_row;
  logic            w_show_end;
  logic            w_exchange;

  assign w_row_idx   = r_row - 3'd1;
  assign w_wr_idx    = bus.wr_addr - 3'd1;
  assign w_front_row = r_bank[r_sel][w_row_idx];
  assign w_show_end  = (r_state == S_SHOW) && (r_cnt == 8'd0);
  assign w_exchange  = r_swap_pending &&
                       ((r_state == S_IDLE) || (w_show_end && (r_row == 3'd7)));

  // Outputs are precomputed for the state being entered so they can be registered.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_func_nxt  = 3'd0;
    w_col_n_nxt = '1;
    case (r_state)
      S_IDLE: begin
        w_row_nxt = 3'd1;
        if (bus.enable) w_state_nxt = S_BLANK;
      end
      S_BLANK: begin
        w_cnt_nxt   = bus.dwell;
        w_state_nxt = S_SHOW;
        w_func_nxt  = r_row;
        w_col_n_nxt = ~w_front_row;
      end
      S_SHOW: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt   = r_cnt - 8'd1;
          w_func_nxt  = r_func;
          w_col_n_nxt = r_col_n;
        end else begin
          w_row_nxt   = (r_row == 3'd7) ? 3'd1 : r_row + 3'd1;
          w_state_nxt = bus.enable ? S_BLANK : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_frame_done_nxt   = (w_state_nxt == S_SHOW) && (w_row_nxt == 3'd7) &&
                         (w_cnt_nxt == 8'd0);
    w_swap_pending_nxt = w_exchange ? 1'b0 : (r_swap_pending | bus.swap);
  end

  // NOTE: the buffers must clear on reset, so they are plain flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_row          <= 3'd1;
      r_cnt          <= 8'd0;
      r_func         <= 3'd0;
      r_col_n        <= '1;
      r_frame_done   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_busy         <= 1'b0;
      r_sel          <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 7; r++)
          r_bank[b][r] <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row          <= w_row_nxt;
      r_cnt          <= w_cnt_nxt;
      r_func         <= w_func_nxt;
      r_col_n        <= w_col_n_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_swap_pending <= w_swap_pending_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      if (w_exchange) r_sel <= ~r_sel;
      // Uses the pre-exchange select, so a coincident write lands in the new front.
      if (bus.wr_en && (bus.wr_addr != 3'd0))
        r_bank[~r_sel][w_wr_idx] <= bus.wr_data;
    end
  end

  assign bus.func         = r_func;
  assign bus.col_n        = r_col_n;
  assign bus.frame_done   = r_frame_done;
  assign bus.swap_pending = r_swap_pending;
  assign bus.busy         = r_busy;

endmodule
